sdr_cpu_arbiter: RTL and testbench
==================================

Name: sdr_cpu_arbiter

Overview:
- Shares the single SDRAM CPU channel (sdr_cpu_*) between two requesters: port A (main V30 CPU, ROM/RAM fetch) and port B (auxiliary: MCU sample fetch / debug readback).
- Sits between the CPU-side request logic and the SDRAM controller, in the CLK_96M domain.
- Provides pulse-request / pulse-ready handshakes on both sides, a starvation guard for B and a response timeout.

Parameters:
- MAX_DEFER, 4: consecutive A grants allowed while B is pending before B is forced.
- TIMEOUT, 255: CLK_96M cycles to wait for sdr_rdy before aborting; 0 disables the timeout.

Ports:
- CLK_96M  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- a_req  in  1  one-cycle request pulse; a_addr/a_din/a_wr_sel are sampled in that cycle
- a_addr  in  24  word address [24:1]
- a_din  in  16  write data
- a_wr_sel  in  2  byte write enables; 00 = read
- a_rdy  out  1  one-cycle completion pulse
- a_dout  out  16  read data, valid from the a_rdy cycle and held until the next A completion
- b_req, b_addr, b_din, b_wr_sel, b_rdy, b_dout: same set and widths as port A
- sdr_req  out  1  one-cycle request pulse to the SDRAM controller
- sdr_addr  out  24  held stable from the sdr_req cycle until completion
- sdr_din  out  16  held stable from the sdr_req cycle until completion
- sdr_wr_sel  out  2  held stable from the sdr_req cycle until completion
- sdr_rdy  in  1  completion pulse from the SDRAM controller
- sdr_dout  in  16  read data, valid in the sdr_rdy cycle
- busy  out  1  high in ISSUE/WAIT or while any request is pending (used for CPU stall)
- timeout_err  out  1  one-cycle pulse on abort
- drop_err  out  1  one-cycle pulse when a request pulse arrives while that port is already pending

Behaviour:
- Reset (async on reset_n low):
  - All outputs 0, except a_dout = b_dout = 16'h0000 and sdr_addr/sdr_din/sdr_wr_sel = 0.
  - Pending flags, defer counter and timeout counter are cleared; state = IDLE.
  - Reset mid-transaction abandons it. Neither x_rdy fires. A later sdr_rdy from the aborted access is discarded in IDLE.
- Request capture:
  - x_req sets pend_x and latches addr/din/wr_sel into per-port holding registers.
  - x_req while pend_x is already set or port x is in flight: request ignored, holding registers unchanged, drop_err pulses.
- IDLE:
  - If any request is pending, select a grant:
    - Only A pending -> A. Only B pending -> B.
    - Both pending -> A, unless defer_cnt == MAX_DEFER, in which case B.
  - Register the grant, copy that port's holding registers onto the sdr_* buses, clear its pend flag, go to ISSUE.
  - A request pulse arriving in IDLE can be granted in the same cycle (combinational bypass into the grant logic).
- ISSUE (1 cycle): sdr_req = 1, timeout counter cleared, -> WAIT.
- WAIT:
  - On sdr_rdy: latch sdr_dout into the granted port's dout, pulse that port's rdy in the next cycle, -> IDLE.
  - Total latency: x_req at cycle N -> sdr_req at N+1 (if idle) -> sdr_rdy at M -> x_rdy at M+1. Next sdr_req no earlier than M+2.
  - Write completions also return sdr_dout; requesters ignore it.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT with no sdr_rdy: granted dout = 16'hFFFF, x_rdy and timeout_err pulse together, -> IDLE.
- Defer counter:
  - Saturating, width clog2(MAX_DEFER+1).
  - Increments on each A grant while pend_b is set.
  - Cleared on a B grant, and on an A grant while B is not pending.
- sdr_rdy outside WAIT is discarded.
  - Known limitation: a late sdr_rdy from a timed-out access that arrives during the following WAIT is accepted as that access's completion.
- Simultaneous a_req and b_req in the same cycle: both captured; arbitration follows the grant rules above.

Decomposition:
- m72_pkg: sdr_arb_state_t enum {ARB_IDLE, ARB_ISSUE, ARB_WAIT}; sdr_arb_port_t enum {ARB_PORT_A, ARB_PORT_B}; constant SDR_ARB_TIMEOUT_DATA = 16'hFFFF.
- One sub-module, sdr_arb_req_hold: per-port pend flag plus the addr/din/wr_sel holding registers and drop_err detect. Instantiated twice.

Test Plan:
- Single A read at addr 24'h000100; sdr_rdy 5 cycles after sdr_req with dout 16'h1234 -> sdr_req one cycle after a_req; a_rdy one cycle after sdr_rdy; a_dout = 16'h1234; b_rdy never fires.
- a_req and b_req in the same cycle, MAX_DEFER=4 -> A served first, then B; sdr_addr sequence matches A then B.
- A re-requests immediately after every a_rdy while B stays pending -> exactly 4 A grants, then B granted; defer counter returns to 0.
- TIMEOUT=8, sdr_rdy withheld -> a_rdy and timeout_err pulse 8 cycles after entering WAIT; a_dout = 16'hFFFF; next pending request then issues normally.
- Second a_req while A is in flight -> drop_err pulse; exactly one sdr_req for A.
- reset_n pulsed low during WAIT -> all outputs 0 immediately; a subsequent stray sdr_rdy produces no x_rdy.

Source files
------------

// File: rtl/m72_pkg.sv
// Shared types for the SDRAM CPU-channel arbiter.
//   sdr_arb_state_t : arbiter FSM states
//   sdr_arb_port_t  : which requester owns the current access
//   sdr_arb_req_t   : one captured request (address, write data, byte enables)
package m72_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} sdr_arb_state_t;
  typedef enum logic {ARB_PORT_A, ARB_PORT_B} sdr_arb_port_t;

  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] din;
    logic [1:0]  wr_sel;
  } sdr_arb_req_t;

  // Read data returned to a requester whose access was aborted.
  localparam logic [15:0] SDR_ARB_TIMEOUT_DATA = 16'hFFFF;
endpackage

// File: rtl/sdr_arb_req_hold.sv
// Per-port request holding stage.
//   gclk, grst_n  : clock, async active-low reset
//   req_i         : one-cycle request pulse, req_data_i sampled with it
//   inflight_i    : this port currently owns the SDRAM access
//   gnt_i         : arbiter consumes this port's request this cycle
//   pend_o        : request available to the arbiter (includes same-cycle bypass)
//   pend_q_o      : registered pending flag
//   data_o        : request fields seen by the arbiter
//   drop_o        : request pulse rejected (already pending or in flight)
module sdr_arb_req_hold
  import m72_pkg::*;
(
  input  logic         gclk,
  input  logic         grst_n,
  input  logic         req_i,
  input  sdr_arb_req_t req_data_i,
  input  logic         inflight_i,
  input  logic         gnt_i,
  output logic         pend_o,
  output logic         pend_q_o,
  output sdr_arb_req_t data_o,
  output logic         drop_o
);
  logic         pend_q, pend_d;
  sdr_arb_req_t hold_q, hold_d;
  logic         accept;

  assign accept   = req_i & ~pend_q & ~inflight_i;
  assign drop_o   = req_i & ~accept;
  assign pend_o   = pend_q | accept;
  // A fresh pulse bypasses the holding register so IDLE can grant it at once.
  assign data_o   = pend_q ? hold_q : req_data_i;
  assign pend_q_o = pend_q;

  always_comb begin
    pend_d = pend_q;
    hold_d = hold_q;
    if (accept) begin
      pend_d = 1'b1;
      hold_d = req_data_i;
    end
    if (gnt_i) pend_d = 1'b0;
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      pend_q <= 1'b0;
      hold_q <= '0;
    end else begin
      pend_q <= pend_d;
      hold_q <= hold_d;
    end
  end
endmodule

// File: rtl/sdr_cpu_arbiter.sv
// Two-port arbiter for the SDRAM CPU channel (CLK_96M domain).
//   Port A (main CPU) / port B (aux): x_req pulse in, x_rdy pulse out,
//     x_dout held until the next completion on that port.
//   sdr_*      : pulse-request / pulse-ready link to the SDRAM controller.
//   busy       : access in progress or any request pending.
//   timeout_err: pulse when an access is aborted for lack of sdr_rdy.
//   drop_err   : pulse (one cycle late) when a request pulse was rejected.
// A wins ties until it has been granted MAX_DEFER times in a row over a
// waiting B; then B is forced.
module sdr_cpu_arbiter
  import m72_pkg::*;
#(
  parameter int MAX_DEFER = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic        CLK_96M,
  input  logic        reset_n,
  input  logic        a_req,
  input  logic [23:0] a_addr,
  input  logic [15:0] a_din,
  input  logic [1:0]  a_wr_sel,
  output logic        a_rdy,
  output logic [15:0] a_dout,
  input  logic        b_req,
  input  logic [23:0] b_addr,
  input  logic [15:0] b_din,
  input  logic [1:0]  b_wr_sel,
  output logic        b_rdy,
  output logic [15:0] b_dout,
  output logic        sdr_req,
  output logic [23:0] sdr_addr,
  output logic [15:0] sdr_din,
  output logic [1:0]  sdr_wr_sel,
  input  logic        sdr_rdy,
  input  logic [15:0] sdr_dout,
  output logic        busy,
  output logic        timeout_err,
  output logic        drop_err
);
  localparam int DW = $clog2(MAX_DEFER + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [DW-1:0] DEFER_MAX = DW'(MAX_DEFER);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  sdr_arb_state_t state_q, state_d;
  sdr_arb_port_t  gnt_q, gnt_d;
  logic [DW-1:0]  defer_q, defer_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  sdr_arb_req_t   sdr_q, sdr_d;
  logic [15:0]    a_dout_q, a_dout_d, b_dout_q, b_dout_d;
  logic           a_rdy_q, a_rdy_d, b_rdy_q, b_rdy_d;
  logic           tmo_err_q, tmo_err_d, drop_q;

  logic         a_pend, b_pend, a_pend_q, b_pend_q, a_drop, b_drop, gnt_a, gnt_b;
  sdr_arb_req_t a_data, b_data;
  logic         active;

  assign active = (state_q != ARB_IDLE);

  sdr_arb_req_hold u_hold_a (
    .gclk(CLK_96M), .grst_n(reset_n), .req_i(a_req),
    .req_data_i('{addr: a_addr, din: a_din, wr_sel: a_wr_sel}),
    .inflight_i(active && gnt_q == ARB_PORT_A), .gnt_i(gnt_a),
    .pend_o(a_pend), .pend_q_o(a_pend_q), .data_o(a_data), .drop_o(a_drop)
  );

  sdr_arb_req_hold u_hold_b (
    .gclk(CLK_96M), .grst_n(reset_n), .req_i(b_req),
    .req_data_i('{addr: b_addr, din: b_din, wr_sel: b_wr_sel}),
    .inflight_i(active && gnt_q == ARB_PORT_B), .gnt_i(gnt_b),
    .pend_o(b_pend), .pend_q_o(b_pend_q), .data_o(b_data), .drop_o(b_drop)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    defer_d   = defer_q;
    tmo_d     = tmo_q;
    sdr_d     = sdr_q;
    a_dout_d  = a_dout_q;
    b_dout_d  = b_dout_q;
    a_rdy_d   = 1'b0;
    b_rdy_d   = 1'b0;
    tmo_err_d = 1'b0;
    gnt_a     = 1'b0;
    gnt_b     = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (a_pend && (!b_pend || defer_q != DEFER_MAX)) begin
          gnt_a   = 1'b1;
          gnt_d   = ARB_PORT_A;
          sdr_d   = a_data;
          // Count A grants that bypassed a waiting B; saturate at the limit.
          defer_d = !b_pend ? '0 : (defer_q == DEFER_MAX) ? defer_q : defer_q + DW'(1);
          state_d = ARB_ISSUE;
        end else if (b_pend) begin
          gnt_b   = 1'b1;
          gnt_d   = ARB_PORT_B;
          sdr_d   = b_data;
          defer_d = '0;
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        tmo_d   = '0;
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (sdr_rdy) begin
          if (gnt_q == ARB_PORT_A) begin a_dout_d = sdr_dout; a_rdy_d = 1'b1; end
          else                     begin b_dout_d = sdr_dout; b_rdy_d = 1'b1; end
          state_d = ARB_IDLE;
        end else if (TIMEOUT != 0 && tmo_q == TMO_LAST) begin
          if (gnt_q == ARB_PORT_A) begin a_dout_d = SDR_ARB_TIMEOUT_DATA; a_rdy_d = 1'b1; end
          else                     begin b_dout_d = SDR_ARB_TIMEOUT_DATA; b_rdy_d = 1'b1; end
          tmo_err_d = 1'b1;
          state_d   = ARB_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK_96M or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ARB_IDLE;
      gnt_q     <= ARB_PORT_A;
      defer_q   <= '0;
      tmo_q     <= '0;
      sdr_q     <= '0;
      a_dout_q  <= '0;
      b_dout_q  <= '0;
      a_rdy_q   <= 1'b0;
      b_rdy_q   <= 1'b0;
      tmo_err_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      defer_q   <= defer_d;
      tmo_q     <= tmo_d;
      sdr_q     <= sdr_d;
      a_dout_q  <= a_dout_d;
      b_dout_q  <= b_dout_d;
      a_rdy_q   <= a_rdy_d;
      b_rdy_q   <= b_rdy_d;
      tmo_err_q <= tmo_err_d;
      drop_q    <= a_drop | b_drop;
    end
  end

  assign sdr_req     = (state_q == ARB_ISSUE);
  assign sdr_addr    = sdr_q.addr;
  assign sdr_din     = sdr_q.din;
  assign sdr_wr_sel  = sdr_q.wr_sel;
  assign a_rdy       = a_rdy_q;
  assign b_rdy       = b_rdy_q;
  assign a_dout      = a_dout_q;
  assign b_dout      = b_dout_q;
  assign busy        = active | a_pend_q | b_pend_q;
  assign timeout_err = tmo_err_q;
  assign drop_err    = drop_q;
endmodule

// File: tb/tb_sdr_cpu_arbiter.sv
module tb_sdr_cpu_arbiter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        a_req = 0, b_req = 0, sdr_rdy = 0;
  logic [23:0] a_addr = 0, b_addr = 0;
  logic [15:0] a_din = 0, b_din = 0, sdr_dout = 0;
  logic [1:0]  a_wr_sel = 0, b_wr_sel = 0;
  logic        a_rdy, b_rdy, sdr_req, busy, timeout_err, drop_err;
  logic [15:0] a_dout, b_dout, sdr_din;
  logic [23:0] sdr_addr;
  logic [1:0]  sdr_wr_sel;

  int errs = 0, checks = 0;

  typedef struct {logic port; logic [15:0] dout;} sb_t;
  sb_t         sb[$];
  logic [23:0] exp_addr[$];

  always #5 clk = ~clk;

  sdr_cpu_arbiter #(.MAX_DEFER(4), .TIMEOUT(8)) dut (
    .CLK_96M(clk), .reset_n(reset_n),
    .a_req(a_req), .a_addr(a_addr), .a_din(a_din), .a_wr_sel(a_wr_sel),
    .a_rdy(a_rdy), .a_dout(a_dout),
    .b_req(b_req), .b_addr(b_addr), .b_din(b_din), .b_wr_sel(b_wr_sel),
    .b_rdy(b_rdy), .b_dout(b_dout),
    .sdr_req(sdr_req), .sdr_addr(sdr_addr), .sdr_din(sdr_din), .sdr_wr_sel(sdr_wr_sel),
    .sdr_rdy(sdr_rdy), .sdr_dout(sdr_dout),
    .busy(busy), .timeout_err(timeout_err), .drop_err(drop_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Wait (bounded) for sdr_req if asked, then answer after dly cycles.
  // Returns in the cycle where the requester's rdy is due.
  task automatic respond(input bit wait_req, input int dly, input logic [15:0] d);
    int n = 0;
    if (wait_req) begin
      while (!sdr_req && n < 20) begin tick(); n++; end
      chk("sdr_req_wait", 32'(n < 20), 32'd1);
    end
    repeat (dly) tick();
    sdr_rdy = 1'b1; sdr_dout = d;
    tick();
    sdr_rdy = 1'b0;
  endtask

  // Scoreboard monitor: grant order and completions.
  always @(negedge clk) begin
    if (sdr_req) begin
      if (exp_addr.size() == 0) chk("sdr_req_unexpected", 32'(sdr_addr), 32'hFFFF_FFFF);
      else chk("sdr_addr_order", 32'(sdr_addr), 32'(exp_addr.pop_front()));
    end
    if (a_rdy || b_rdy) begin
      if (sb.size() == 0) chk("rdy_unexpected", {30'd0, a_rdy, b_rdy}, 32'd0);
      else begin
        sb_t e;
        e = sb.pop_front();
        chk("rdy_port", {30'd0, a_rdy, b_rdy}, e.port ? 32'd1 : 32'd2);
        chk("rdy_dout", 32'(b_rdy ? b_dout : a_dout), 32'(e.dout));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_outs", {26'd0, sdr_req, a_rdy, b_rdy, busy, timeout_err, drop_err}, 32'd0);
    chk("rst_dout", {a_dout, b_dout}, 32'd0);
    chk("rst_sdr_bus", {6'd0, sdr_wr_sel, sdr_addr}, 32'd0);
    reset_n = 1'b1;
    tick();

    // 1: single A read
    exp_addr.push_back(24'h000100); sb.push_back('{1'b0, 16'h1234});
    a_req = 1; a_addr = 24'h000100; a_wr_sel = 2'b00;
    tick(); a_req = 0;
    chk("t1_sdr_req_latency", 32'(sdr_req), 32'd1);
    chk("t1_sdr_addr", 32'(sdr_addr), 32'h100);
    respond(1'b0, 5, 16'h1234);
    chk("t1_a_rdy", 32'(a_rdy), 32'd1);
    chk("t1_b_rdy", 32'(b_rdy), 32'd0);
    chk("t1_a_dout", 32'(a_dout), 32'h1234);
    tick();
    chk("t1_a_rdy_pulse", 32'(a_rdy), 32'd0);

    // 2: simultaneous A and B
    exp_addr.push_back(24'h000200); exp_addr.push_back(24'h000300);
    sb.push_back('{1'b0, 16'hAAAA}); sb.push_back('{1'b1, 16'hBBBB});
    a_req = 1; a_addr = 24'h000200; b_req = 1; b_addr = 24'h000300;
    tick(); a_req = 0; b_req = 0;
    chk("t2_busy", 32'(busy), 32'd1);
    respond(1'b1, 2, 16'hAAAA);
    respond(1'b1, 2, 16'hBBBB);
    chk("t2_douts", {a_dout, b_dout}, 32'hAAAA_BBBB);
    tick();

    // 3: A keeps re-requesting while B waits -> B forced after 4 A grants
    for (int k = 0; k < 4; k++) exp_addr.push_back(24'h000500 + 24'(k));
    exp_addr.push_back(24'h000400); exp_addr.push_back(24'h000504);
    for (int k = 0; k < 4; k++) sb.push_back('{1'b0, 16'hC000 + 16'(k)});
    sb.push_back('{1'b1, 16'hC004}); sb.push_back('{1'b0, 16'hC005});
    a_req = 1; a_addr = 24'h000500; b_req = 1; b_addr = 24'h000400;
    tick(); a_req = 0; b_req = 0;
    for (int k = 0; k < 4; k++) begin
      respond(1'b1, 1, 16'hC000 + 16'(k));
      a_req = 1; a_addr = 24'h000501 + 24'(k);
      tick(); a_req = 0;
      if (k == 2) chk("t3_defer_sat", 32'(dut.defer_q), 32'd4);
    end
    chk("t3_b_forced", 32'(sdr_addr), 32'h400);
    chk("t3_defer_clr", 32'(dut.defer_q), 32'd0);
    respond(1'b1, 1, 16'hC004);
    respond(1'b1, 1, 16'hC005);
    chk("t3_defer_end", 32'(dut.defer_q), 32'd0);
    tick();

    // 4: timeout on A, B queued during WAIT issues afterwards
    exp_addr.push_back(24'h000600); exp_addr.push_back(24'h000700);
    sb.push_back('{1'b0, 16'hFFFF}); sb.push_back('{1'b1, 16'h7777});
    a_req = 1; a_addr = 24'h000600;
    tick(); a_req = 0;                 // ISSUE
    repeat (2) tick();
    b_req = 1; b_addr = 24'h000700;
    tick(); b_req = 0;
    repeat (2) tick();
    chk("t4_busy_wait", 32'(busy), 32'd1);
    repeat (3) tick();                 // 7 cycles into WAIT
    chk("t4_no_early_abort", {30'd0, a_rdy, timeout_err}, 32'd0);
    tick();
    chk("t4_abort", {30'd0, a_rdy, timeout_err}, 32'd3);
    chk("t4_a_dout", 32'(a_dout), 32'hFFFF);
    respond(1'b1, 2, 16'h7777);
    chk("t4_b_dout", 32'(b_dout), 32'h7777);
    tick();

    // 5: second A pulse while A in flight is dropped
    exp_addr.push_back(24'h000800); sb.push_back('{1'b0, 16'h8888});
    a_req = 1; a_addr = 24'h000800; a_din = 16'h5555; a_wr_sel = 2'b11;
    tick();                            // ISSUE, second pulse now
    chk("t5_sdr_din", {14'd0, sdr_wr_sel, sdr_din}, 32'h0003_5555);
    a_addr = 24'h000900; a_din = 16'h0; a_wr_sel = 2'b00;
    tick(); a_req = 0;
    chk("t5_drop_err", 32'(drop_err), 32'd1);
    tick();
    chk("t5_drop_pulse", 32'(drop_err), 32'd0);
    respond(1'b0, 1, 16'h8888);
    repeat (4) tick();
    chk("t5_single_grant", 32'(exp_addr.size()), 32'd0);
    chk("t5_idle", 32'(busy), 32'd0);

    // 6: reset during WAIT, stray sdr_rdy afterwards
    exp_addr.push_back(24'h000A00);
    a_req = 1; a_addr = 24'h000A00;
    tick(); a_req = 0;
    repeat (2) tick();
    reset_n = 1'b0; #1;
    chk("t6_rst_outs", {26'd0, sdr_req, a_rdy, b_rdy, busy, timeout_err, drop_err}, 32'd0);
    chk("t6_rst_dout", {a_dout, b_dout}, 32'd0);
    chk("t6_rst_addr", 32'(sdr_addr), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    sdr_rdy = 1; sdr_dout = 16'hDEAD;
    tick(); sdr_rdy = 0;
    chk("t6_no_rdy", {30'd0, a_rdy, b_rdy}, 32'd0);
    tick();
    chk("t6_dout_kept", 32'(a_dout), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("addr_q_empty", 32'(exp_addr.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
